// File: rtl/logs_iter_seq_if.sv
// Handshake bundle between the r-sweep logic (master) and the logistic-map sequencer (slave).
interface logs_iter_seq_if #(
    parameter int FRAC = 8
);
    logic            step;
    logic [FRAC+1:0] r;
    logic [FRAC-1:0] x;
    logic            next_ready;
    logic            busy;

    modport master (output step, r, input x, next_ready, busy);
    modport slave  (input step, r, output x, next_ready, busy);
endinterface

// File: rtl/logs_iter_seq.sv
// Logistic-map sequencer: x <- r*x*(1-x) using one shared LSB-first shift-add multiplier,
// two FRAC-cycle multiply phases per step, reseeding on the zero fixed point.
module logs_iter_seq #(
    parameter int FRAC   = 8,
    parameter int X_SEED = 128
) (
    input  logic           clk,
    input  logic           reset,
    logs_iter_seq_if.slave bus
);
    localparam int AW = 2*FRAC + 2;
    localparam int MW = FRAC + 2;
    localparam int CW = $clog2(FRAC);

    typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [MW-1:0]   r_mcand;
    logic [FRAC-1:0] r_mplier;
    logic [MW-1:0]   r_rq;
    logic [CW-1:0]   r_cnt;
    logic [FRAC-1:0] r_x;
    logic            r_nrdy;

    logic            w_last;
    logic            w_busy;
    logic [FRAC:0]   w_compl;
    logic [AW-1:0]   w_addend;
    logic [AW-1:0]   w_acc_nxt;
    logic [FRAC-1:0] w_res;

    assign w_last  = (r_cnt == CW'(FRAC-1));
    assign w_compl = {1'b1, {FRAC{1'b0}}} - {1'b0, bus.x};

    // (acc + m<<FRAC) >> 1 == (acc >> 1) + m<<(FRAC-1) because m<<FRAC is even
    assign w_addend  = r_mplier[0] ? {1'b0, r_mcand, {(FRAC-1){1'b0}}} : '0;
    assign w_acc_nxt = (r_acc >> 1) + w_addend;
    assign w_res     = w_acc_nxt[2*FRAC-1:FRAC];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.step) w_state_nxt = S_MUL1;
            S_MUL1:  if (w_last)   w_state_nxt = S_MUL2;
            S_MUL2:  if (w_last)   w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rq     <= '0;
            r_cnt    <= '0;
            r_x      <= FRAC'(X_SEED);
            r_nrdy   <= 1'b0;
        end else begin
            r_nrdy <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.step) begin
                        r_rq     <= bus.r;
                        r_mplier <= bus.x;
                        r_mcand  <= {1'b0, w_compl};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL1: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        // a = x(1-x) becomes the multiplier, r the multiplicand
                        r_mplier <= w_res;
                        r_mcand  <= r_rq;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL2: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_x    <= (w_res == '0) ? FRAC'(X_SEED) : w_res;
                        r_nrdy <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.x          = r_x;
    assign bus.next_ready = r_nrdy;
    assign bus.busy       = w_busy;
endmodule

// File: tb/tb_logs_iter_seq.sv
// Scoreboard bench for logs_iter_seq: integer reference model of the truncating iteration.
module tb_logs_iter_seq;
    logic clk = 1'b0;
    logic reset;

    logs_iter_seq_if #(.FRAC(8)) ifc ();

    logs_iter_seq #(.FRAC(8), .X_SEED(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         nr_cnt = 0;
    logic [7:0] sbq[$];
    logic [7:0] m_x;

    always @(negedge clk) if (ifc.next_ready === 1'b1) nr_cnt++;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [7:0] xv, input logic [9:0] rv);
        int a, b;
        a = (int'(xv) * (256 - int'(xv))) / 256;
        b = (int'(rv) * a) / 256;
        if (b == 0) return 8'd128;
        return 8'(b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.step = 1'b0;
        ifc.r = '0;
        tick();
        tick();
        reset = 1'b0;
        m_x = 8'd128;
        sbq.delete();
    endtask

    // Accept one step in the current cycle and follow it until next_ready (cycle 17 nominally).
    task automatic run_iter(input logic [9:0] rv, input int pa, input int pb, input int rc,
                            input logic [9:0] rcv, output int lat, output int bcnt,
                            output bit xchg, output bit tmo);
        logic [7:0] x0;
        x0 = ifc.x;
        ifc.step = 1'b1;
        ifc.r = rv;
        m_x = model(m_x, rv);
        sbq.push_back(m_x);
        lat = 0; bcnt = 0; xchg = 1'b0; tmo = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ifc.next_ready === 1'b1) begin
                lat = c;
                tmo = 1'b0;
                break;
            end
            if (ifc.busy === 1'b1) bcnt++;
            if (ifc.x !== x0) xchg = 1'b1;
            ifc.step = (c == pa) || (c == pb);
            if (c == rc) ifc.r = rcv;
        end
        ifc.step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifc.x !== 8'd128) begin errors++; $display("FAIL reset_x got %0d want 128", ifc.x); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        checks++; if (ifc.next_ready !== 1'b0) begin errors++; $display("FAIL reset_nrdy got %b want 0", ifc.next_ready); end
    endtask

    task automatic test_first();
        int lat, bcnt; bit xchg, tmo; logic [7:0] exp;
        do_reset();
        checks++; if (ifc.x !== 8'd128) begin errors++; $display("FAIL first_x_before got %0d want 128", ifc.x); end
        run_iter(10'd272, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL first_timeout got none want next_ready"); end
        checks++; if (lat != 17) begin errors++; $display("FAIL first_latency got %0d want 17", lat); end
        checks++; if (bcnt != 16) begin errors++; $display("FAIL first_busy_cycles got %0d want 16", bcnt); end
        checks++; if (xchg) begin errors++; $display("FAIL first_x_early got changed want stable"); end
        exp = sbq.pop_front();
        checks++; if (ifc.x !== exp) begin errors++; $display("FAIL first_x got %0d want %0d", ifc.x, exp); end
        checks++; if (ifc.x !== 8'd68) begin errors++; $display("FAIL first_x_const got %0d want 68", ifc.x); end
    endtask

    task automatic test_sequence();
        int rv[3] = '{272, 700, 1000};
        int wait_c, nr;
        logic [7:0] exp;
        ifc.step = 1'b1;
        ifc.r = 10'd272;
        m_x = model(m_x, 10'd272);
        sbq.push_back(m_x);
        for (int seg = 0; seg < 3; seg++) begin
            for (int n = 0; n < 1000; n++) begin
                wait_c = 0;
                do begin
                    tick();
                    wait_c++;
                end while (ifc.next_ready !== 1'b1 && wait_c < 40);
                checks++;
                if (ifc.next_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL seq_timeout got no next_ready want pulse (seg %0d iter %0d)", seg, n);
                    ifc.step = 1'b0;
                    return;
                end
                exp = sbq.pop_front();
                checks++; if (ifc.x !== exp) begin errors++; $display("FAIL seq_x got %0d want %0d (seg %0d iter %0d)", ifc.x, exp, seg, n); end
                checks++; if (wait_c != 17) begin errors++; $display("FAIL seq_period got %0d want 17", wait_c); end
                if (seg == 0 && n == 0) begin
                    checks++; if (ifc.x !== 8'd52) begin errors++; $display("FAIL seq_x1_const got %0d want 52", ifc.x); end
                end
                if (seg == 0 && n == 1) begin
                    checks++; if (ifc.x !== 8'd43) begin errors++; $display("FAIL seq_x2_const got %0d want 43", ifc.x); end
                end
                if (seg == 2 && n == 999) begin
                    ifc.step = 1'b0;
                end else begin
                    nr = (n == 999) ? rv[seg+1] : rv[seg];
                    ifc.r = 10'(nr);
                    m_x = model(m_x, 10'(nr));
                    sbq.push_back(m_x);
                end
            end
        end
        tick();
    endtask

    task automatic test_max_r();
        int lat, bcnt; bit xchg, tmo; logic [7:0] exp;
        do_reset();
        run_iter(10'd1023, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        exp = sbq.pop_front();
        checks++; if (tmo || ifc.x !== exp) begin errors++; $display("FAIL maxr_x got %0d want %0d", ifc.x, exp); end
        checks++; if (ifc.x !== 8'd255) begin errors++; $display("FAIL maxr_x_const got %0d want 255", ifc.x); end
        run_iter(10'd1023, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        exp = sbq.pop_front();
        checks++; if (tmo || ifc.x !== exp) begin errors++; $display("FAIL maxr_reseed got %0d want %0d", ifc.x, exp); end
        checks++; if (ifc.x !== 8'd128) begin errors++; $display("FAIL maxr_reseed_const got %0d want 128", ifc.x); end
    endtask

    task automatic test_zero_r();
        int lat, bcnt; bit xchg, tmo; logic [7:0] exp;
        run_iter(10'd272, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        exp = sbq.pop_front();
        checks++; if (tmo || ifc.x !== exp) begin errors++; $display("FAIL zeror_pre got %0d want %0d", ifc.x, exp); end
        run_iter(10'd0, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        checks++; if (lat != 17) begin errors++; $display("FAIL zeror_latency got %0d want 17", lat); end
        exp = sbq.pop_front();
        checks++; if (ifc.x !== exp) begin errors++; $display("FAIL zeror_x got %0d want %0d", ifc.x, exp); end
        checks++; if (ifc.x !== 8'd128) begin errors++; $display("FAIL zeror_x_const got %0d want 128", ifc.x); end
    endtask

    task automatic test_ignored();
        int lat, bcnt, n0, busyc; bit xchg, tmo; logic [7:0] exp;
        do_reset();
        n0 = nr_cnt;
        run_iter(10'd272, 3, 10, 5, 10'd1023, lat, bcnt, xchg, tmo);
        checks++; if (lat != 17) begin errors++; $display("FAIL ign_latency got %0d want 17", lat); end
        exp = sbq.pop_front();
        checks++; if (ifc.x !== exp) begin errors++; $display("FAIL ign_x got %0d want %0d", ifc.x, exp); end
        busyc = 0;
        repeat (30) begin
            tick();
            if (ifc.busy === 1'b1) busyc++;
        end
        checks++; if (busyc != 0) begin errors++; $display("FAIL ign_extra_iter got %0d busy cycles want 0", busyc); end
        checks++; if (nr_cnt - n0 != 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", nr_cnt - n0); end
        ifc.r = 10'd272;
    endtask

    task automatic test_mid_reset();
        int lat, bcnt, n0, busyc; bit xchg, tmo; logic [7:0] exp;
        do_reset();
        n0 = nr_cnt;
        ifc.step = 1'b1;
        ifc.r = 10'd272;
        tick();
        ifc.step = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (ifc.x !== 8'd128) begin errors++; $display("FAIL mrst_x got %0d want 128", ifc.x); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", ifc.busy); end
        busyc = 0;
        repeat (30) begin
            tick();
            if (ifc.busy === 1'b1) busyc++;
        end
        checks++; if (nr_cnt != n0 || busyc != 0) begin errors++; $display("FAIL mrst_aborted got %0d pulses %0d busy want 0 0", nr_cnt - n0, busyc); end
        m_x = 8'd128;
        run_iter(10'd272, -1, -1, -1, 10'd0, lat, bcnt, xchg, tmo);
        checks++; if (lat != 17 || bcnt != 16) begin errors++; $display("FAIL mrst_timing got lat %0d busy %0d want 17 16", lat, bcnt); end
        exp = sbq.pop_front();
        checks++; if (ifc.x !== exp) begin errors++; $display("FAIL mrst_x_after got %0d want %0d", ifc.x, exp); end
    endtask

    initial begin
        reset = 1'b1;
        ifc.step = 1'b0;
        ifc.r = '0;
        m_x = 8'd128;
        test_reset();
        test_first();
        test_sequence();
        test_max_r();
        test_zero_r();
        test_ignored();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
